// File: rtl/ps2_scancode_decoder_pkg.sv
// ps2_scancode_decoder_pkg: Set-2 scancode constants, prefix-parser states and the key event type.
package ps2_scancode_decoder_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0, ST_PAUSE} state_t;
  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE    = 8'hE1;
  localparam logic [7:0] SC_BAT_OK   = 8'hAA;
  localparam logic [7:0] SC_BAT_FAIL = 8'hFC;
  localparam logic [7:0] SC_ACK      = 8'hFA;
  localparam logic [7:0] SC_ECHO     = 8'hEE;
  localparam logic [7:0] SC_RESEND   = 8'hFE;
  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;
  localparam logic [7:0] SC_CTRL     = 8'h14;
  localparam logic [7:0] SC_ALT      = 8'h11;
  localparam logic [7:0] SC_PAUSE_EV = 8'h77;
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } event_t;
  function automatic logic is_ignored(input logic [7:0] b);
    return b inside {SC_ACK, SC_ECHO, SC_RESEND, 8'h00, 8'hFF};
  endfunction
  // E0 12 / E0 59 are the fake shifts some keyboards wrap around extended keys
  function automatic logic is_fake_shift(input logic [7:0] b);
    return b == SC_LSHIFT || b == SC_RSHIFT;
  endfunction
endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if: received-byte input and key-event/status outputs of the decoder.
interface ps2_scancode_decoder_if #(parameter int ERR_W = 4, parameter int EVCNT_W = 8);
  logic               i_byte_valid;
  logic [7:0]         i_byte_data;
  logic               i_byte_err;
  logic               o_ev_valid;
  logic [7:0]         o_ev_code;
  logic               o_ev_ext;
  logic               o_ev_break;
  logic [EVCNT_W-1:0] o_ev_count;
  logic [3:0]         o_mods;
  logic [127:0]       o_key_down;
  logic [ERR_W-1:0]   o_err_count;
  logic               o_bat_ok;
  modport master (output i_byte_valid, i_byte_data, i_byte_err,
                  input  o_ev_valid, o_ev_code, o_ev_ext, o_ev_break, o_ev_count,
                         o_mods, o_key_down, o_err_count, o_bat_ok);
  modport slave  (input  i_byte_valid, i_byte_data, i_byte_err,
                  output o_ev_valid, o_ev_code, o_ev_ext, o_ev_break, o_ev_count,
                         o_mods, o_key_down, o_err_count, o_bat_ok);
endinterface

// File: rtl/ps2_scancode_decoder_key_tracker.sv
// ps2_key_tracker: folds key events into a pressed-key bitmap and modifier flags.
module ps2_key_tracker
  import ps2_scancode_decoder_pkg::*;
(
  input  logic         PS2_CLK,
  input  logic         reset,
  input  logic         i_valid,
  input  event_t       i_ev,
  output logic [127:0] o_key_down,
  output logic [3:0]   o_mods
);
  logic [127:0] r_key_down;
  logic [3:0]   r_mods;
  always_ff @(posedge PS2_CLK or posedge reset) begin
    if (reset) begin
      r_key_down <= '0;
      r_mods     <= '0;
    end else if (i_valid) begin
      if (!i_ev.ext && !i_ev.code[7]) r_key_down[i_ev.code[6:0]] <= !i_ev.brk;
      if (!i_ev.ext && i_ev.code == SC_LSHIFT) r_mods[0] <= !i_ev.brk;
      if (!i_ev.ext && i_ev.code == SC_RSHIFT) r_mods[1] <= !i_ev.brk;
      if (i_ev.code == SC_CTRL) r_mods[2] <= !i_ev.brk;
      if (i_ev.code == SC_ALT) r_mods[3] <= !i_ev.brk;
    end
  end
  assign o_key_down = r_key_down;
  assign o_mods     = r_mods;
endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: Set-2 prefix parser turning received bytes into key events plus status.
module ps2_scancode_decoder
  import ps2_scancode_decoder_pkg::*;
#(
  parameter int ERR_W   = 4,
  parameter int EVCNT_W = 8
) (
  input logic PS2_CLK,
  input logic reset,
  ps2_scancode_decoder_if.slave bus
);
  state_t             r_state, w_nstate;
  logic [2:0]         r_cnt, w_ncnt;
  logic               r_ev_valid;
  event_t             r_ev, w_ev;
  logic [EVCNT_W-1:0] r_ev_count;
  logic [ERR_W-1:0]   r_err;
  logic               r_bat_ok;
  logic               w_fire, w_go, w_bat_set, w_bat_clr;
  logic [7:0]         w_b;
  assign w_b = bus.i_byte_data;
  always_comb begin
    w_nstate  = r_state;
    w_ncnt    = r_cnt;
    w_fire    = 1'b0;
    w_bat_set = 1'b0;
    w_bat_clr = 1'b0;
    w_ev      = '{code: w_b, ext: 1'b0, brk: 1'b0};
    if (bus.i_byte_err) w_nstate = ST_IDLE;
    else
      case (r_state)
        ST_IDLE: begin
          w_nstate  = w_b == SC_EXT ? ST_E0 : w_b == SC_BREAK ? ST_F0 :
                      w_b == SC_PAUSE ? ST_PAUSE : ST_IDLE;
          w_ncnt    = w_b == SC_PAUSE ? 3'd7 : r_cnt;
          w_bat_set = w_b == SC_BAT_OK;
          w_bat_clr = w_b == SC_BAT_FAIL;
          w_fire    = !(w_b inside {SC_EXT, SC_BREAK, SC_PAUSE, SC_BAT_OK, SC_BAT_FAIL}) &&
                      !is_ignored(w_b);
        end
        ST_E0: begin
          w_nstate = w_b == SC_BREAK ? ST_E0F0 : w_b == SC_EXT ? ST_E0 : ST_IDLE;
          w_ev.ext = 1'b1;
          w_fire   = !(w_b inside {SC_BREAK, SC_EXT}) && !is_fake_shift(w_b);
        end
        ST_F0: begin
          w_nstate = w_b == SC_BREAK ? ST_F0 : ST_IDLE;
          w_ev.brk = 1'b1;
          w_fire   = w_b != SC_BREAK;
        end
        ST_E0F0: begin
          w_nstate = w_b == SC_BREAK ? ST_E0F0 : ST_IDLE;
          w_ev.ext = 1'b1;
          w_ev.brk = 1'b1;
          w_fire   = w_b != SC_BREAK && !is_fake_shift(w_b);
        end
        ST_PAUSE: begin
          // the E1 sequence carries no key of its own; it collapses into one extended 77 make
          w_ncnt   = r_cnt - 3'd1;
          w_nstate = r_cnt == 3'd1 ? ST_IDLE : ST_PAUSE;
          w_fire   = r_cnt == 3'd1;
          w_ev     = '{code: SC_PAUSE_EV, ext: 1'b1, brk: 1'b0};
        end
        default: w_nstate = ST_IDLE;
      endcase
  end
  assign w_go = bus.i_byte_valid && !bus.i_byte_err && w_fire;
  always_ff @(posedge PS2_CLK or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_ev_valid <= 1'b0;
      r_ev       <= '0;
      r_ev_count <= '0;
      r_err      <= '0;
      r_bat_ok   <= 1'b0;
    end else begin
      r_ev_valid <= w_go;
      if (bus.i_byte_valid) begin
        r_state <= w_nstate;
        r_cnt   <= w_ncnt;
        if (w_go) begin
          r_ev       <= w_ev;
          r_ev_count <= r_ev_count + EVCNT_W'(1);
        end
        if (bus.i_byte_err && !(&r_err)) r_err <= r_err + ERR_W'(1);
        if (w_bat_set) r_bat_ok <= 1'b1;
        if (w_bat_clr) r_bat_ok <= 1'b0;
      end
    end
  end
  ps2_key_tracker u_tracker (
    .PS2_CLK    (PS2_CLK),
    .reset      (reset),
    .i_valid    (w_go),
    .i_ev       (w_ev),
    .o_key_down (bus.o_key_down),
    .o_mods     (bus.o_mods)
  );
  assign bus.o_ev_valid  = r_ev_valid;
  assign bus.o_ev_code   = r_ev.code;
  assign bus.o_ev_ext    = r_ev.ext;
  assign bus.o_ev_break  = r_ev.brk;
  assign bus.o_ev_count  = r_ev_count;
  assign bus.o_err_count = r_err;
  assign bus.o_bat_ok    = r_bat_ok;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed byte sequences checked against a prefix-flag reference model.
module tb_ps2_scancode_decoder;
  logic PS2_CLK = 1'b0;
  logic reset   = 1'b1;
  int checks = 0;
  int errors = 0;
  ps2_scancode_decoder_if #(.ERR_W(4), .EVCNT_W(8)) bus ();
  ps2_scancode_decoder #(.ERR_W(4), .EVCNT_W(8)) dut (
    .PS2_CLK (PS2_CLK),
    .reset   (reset),
    .bus     (bus)
  );
  always #5 PS2_CLK = ~PS2_CLK;
  // reference state: pending prefix flags and a countdown of remaining pause bytes
  bit           m_ext, m_brk;
  int           m_pause, m_err;
  bit           m_evv, m_x, m_k, m_bat;
  logic [7:0]   m_code, m_cnt;
  logic [3:0]   m_mods;
  logic [127:0] m_kd;
  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_pause = 0; m_err = 0; m_evv = 0; m_x = 0; m_k = 0;
    m_bat = 0; m_code = 0; m_cnt = 0; m_mods = 0; m_kd = '0;
  endtask
  task automatic emit(input logic [7:0] c, input bit x, input bit k);
    m_evv = 1; m_code = c; m_x = x; m_k = k; m_cnt = m_cnt + 8'd1;
    if (!x && c < 8'h80) m_kd[c[6:0]] = !k;
    if (!x && c == 8'h12) m_mods[0] = !k;
    if (!x && c == 8'h59) m_mods[1] = !k;
    if (c == 8'h14) m_mods[2] = !k;
    if (c == 8'h11) m_mods[3] = !k;
  endtask
  task automatic model(input logic [7:0] b, input bit e);
    m_evv = 0;
    if (e) begin
      if (m_err < 15) m_err++;
      m_ext = 0; m_brk = 0; m_pause = 0;
    end else if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) emit(8'h77, 1, 0);
    end else if (!m_ext && !m_brk && b == 8'hE1) m_pause = 7;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0 && !m_brk) m_ext = 1;
    else if (!m_ext && !m_brk && b inside {8'hAA, 8'hFC, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
      if (b == 8'hAA) m_bat = 1;
      if (b == 8'hFC) m_bat = 0;
    end else if (m_ext && (b == 8'h12 || b == 8'h59)) begin
      m_ext = 0; m_brk = 0;
    end else begin
      emit(b, m_ext, m_brk);
      m_ext = 0; m_brk = 0;
    end
  endtask
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    end
  endtask
  always @(posedge PS2_CLK) begin
    #1;
    chk("ev_valid", 128'(bus.o_ev_valid), 128'(m_evv));
    if (m_evv) begin
      chk("ev_code", 128'(bus.o_ev_code), 128'(m_code));
      chk("ev_ext", 128'(bus.o_ev_ext), 128'(m_x));
      chk("ev_break", 128'(bus.o_ev_break), 128'(m_k));
    end
    chk("ev_count", 128'(bus.o_ev_count), 128'(m_cnt));
    chk("mods", 128'(bus.o_mods), 128'(m_mods));
    chk("key_down", bus.o_key_down, m_kd);
    chk("err_count", 128'(bus.o_err_count), 128'(m_err));
    chk("bat_ok", 128'(bus.o_bat_ok), 128'(m_bat));
  end
  task automatic send(input logic [7:0] b, input bit e = 0);
    bus.i_byte_data = b; bus.i_byte_err = e; bus.i_byte_valid = 1'b1;
    model(b, e);
    @(negedge PS2_CLK);
    bus.i_byte_valid = 1'b0; bus.i_byte_err = 1'b0;
    m_evv = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    logic [127:0] kd_exp;
    model_reset();
    bus.i_byte_valid = 1'b0; bus.i_byte_data = 8'h00; bus.i_byte_err = 1'b0;
    repeat (3) @(negedge PS2_CLK);
    chk("reset ev_count", 128'(bus.o_ev_count), 128'd0);
    chk("reset key_down", bus.o_key_down, 128'd0);
    reset = 1'b0;
    @(negedge PS2_CLK);
    send(8'h1C);
    chk("1C valid", 128'(bus.o_ev_valid), 128'd1);
    chk("1C code", 128'(bus.o_ev_code), 128'h1C);
    chk("1C break", 128'(bus.o_ev_break), 128'd0);
    chk("1C key_down", 128'(bus.o_key_down[8'h1C]), 128'd1);
    chk("1C count", 128'(bus.o_ev_count), 128'd1);
    send(8'hF0);
    chk("F0 no event", 128'(bus.o_ev_valid), 128'd0);
    send(8'h1C);
    chk("1C release break", 128'(bus.o_ev_break), 128'd1);
    chk("1C release key_down", 128'(bus.o_key_down[8'h1C]), 128'd0);
    send(8'hE0); send(8'h75);
    chk("E0 75 ext", 128'(bus.o_ev_ext), 128'd1);
    chk("E0 75 break", 128'(bus.o_ev_break), 128'd0);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("E0 F0 75 ext", 128'(bus.o_ev_ext), 128'd1);
    chk("E0 F0 75 break", 128'(bus.o_ev_break), 128'd1);
    chk("ext key_down", bus.o_key_down, 128'd0);
    chk("ext count", 128'(bus.o_ev_count), 128'd4);
    for (int i = 0; i < 8; i++) begin
      send(pause_seq[i]);
      chk("pause valid", 128'(bus.o_ev_valid), 128'(i == 7));
    end
    chk("pause code", 128'(bus.o_ev_code), 128'h77);
    chk("pause ext", 128'(bus.o_ev_ext), 128'd1);
    chk("pause mods", 128'(bus.o_mods), 128'd0);
    chk("pause count", 128'(bus.o_ev_count), 128'd5);
    send(8'hE0); send(8'h55, 1); send(8'h1C);
    chk("err drops E0 ext", 128'(bus.o_ev_ext), 128'd0);
    chk("err drops E0 code", 128'(bus.o_ev_code), 128'h1C);
    chk("err_count 1", 128'(bus.o_err_count), 128'd1);
    for (int i = 0; i < 16; i++) send(8'(i), 1);
    chk("err_count sat", 128'(bus.o_err_count), 128'hF);
    send(8'h12);
    chk("lshift mods", 128'(bus.o_mods), 128'b0001);
    send(8'hE0); send(8'h12);
    chk("fake shift no event", 128'(bus.o_ev_valid), 128'd0);
    chk("fake shift count", 128'(bus.o_ev_count), 128'd7);
    send(8'hAA);
    chk("bat_ok set", 128'(bus.o_bat_ok), 128'd1);
    send(8'hFA);
    chk("ack no event", 128'(bus.o_ev_valid), 128'd0);
    send(8'h83);
    kd_exp = (128'd1 << 8'h1C) | (128'd1 << 8'h12);
    chk("83 event", 128'(bus.o_ev_code), 128'h83);
    chk("83 key_down", bus.o_key_down, kd_exp);
    send(8'hE0); send(8'h14);
    chk("rctrl mods", 128'(bus.o_mods), 128'b0101);
    send(8'hF0); send(8'h14);
    chk("lctrl break mods", 128'(bus.o_mods), 128'b0001);
    send(8'hFC);
    chk("bat_ok clear", 128'(bus.o_bat_ok), 128'd0);
    send(8'hF0);
    #1 reset = 1'b1; model_reset();
    #2 reset = 1'b0;
    @(negedge PS2_CLK);
    send(8'h1C);
    chk("post reset make", 128'(bus.o_ev_break), 128'd0);
    chk("post reset count", 128'(bus.o_ev_count), 128'd1);
    repeat (2) @(negedge PS2_CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
